// File: rtl/mp5_phantom_ctrl.sv
// mp5 stage phantom-reservation controller.
// Tracks phantom pushes (id -> fifo/slot) in a small map, resolves real
// packets into insert commands for the reserved slot, and retires stale
// reservations by age.
//
// state  | meaning
// IDLE   | resolver free, accepting a fill request
// LOOKUP | latched fill id compared against the map this cycle
// ISSUE  | insert command held on the stage port until accepted
module mp5_phantom_ctrl #(
  parameter int NUM_PIPELINES = 8,
  parameter int FIFO_SIZE     = 8,
  parameter int MAP_ENTRIES   = 16,
  parameter int ID_W          = 16,
  parameter int TIMEOUT       = 255,
  localparam int FW = $clog2(NUM_PIPELINES),
  localparam int AW = $clog2(FIFO_SIZE),
  localparam int IW = $clog2(MAP_ENTRIES),
  localparam int OW = IW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reserve_valid,
  input  logic [ID_W-1:0] reserve_id,
  input  logic [FW-1:0]   reserve_fifo,
  input  logic [AW-1:0]   reserve_addr,
  output logic            reserve_ready,
  input  logic            fill_valid,
  input  logic [ID_W-1:0] fill_id,
  output logic            fill_ready,
  output logic            insert_valid,
  output logic [FW-1:0]   insert_fifo,
  output logic [AW-1:0]   insert_addr,
  output logic [ID_W-1:0] insert_id,
  input  logic            insert_ready,
  output logic            miss_pulse,
  output logic            dup_pulse,
  output logic            timeout_pulse,
  output logic [FW-1:0]   timeout_fifo,
  output logic [AW-1:0]   timeout_addr,
  output logic [OW-1:0]   occupancy
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_t;

  localparam logic [7:0] AGE_MAX = 8'(TIMEOUT);

  state_t          state;
  logic [ID_W-1:0] fill_id_q;

  logic            ent_valid [MAP_ENTRIES];
  logic [ID_W-1:0] ent_id    [MAP_ENTRIES];
  logic [FW-1:0]   ent_fifo  [MAP_ENTRIES];
  logic [AW-1:0]   ent_addr  [MAP_ENTRIES];
  logic [7:0]      ent_age   [MAP_ENTRIES];

  logic          dup_hit;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          hit_found;
  logic [IW-1:0] hit_idx;
  logic          to_found;
  logic [IW-1:0] to_idx;
  logic          do_alloc;
  logic          dup_fire;

  assign reserve_ready = (occupancy < OW'(MAP_ENTRIES));
  assign fill_ready    = (state == IDLE);
  assign do_alloc      = reserve_valid & reserve_ready & ~dup_hit;
  assign dup_fire      = reserve_valid & reserve_ready & dup_hit;

  // Map searches on the start-of-cycle contents: dup check, lowest free slot,
  // lookup hit, and lowest expired entry (an entry claimed by the lookup is
  // not also reported as a timeout).
  always_comb begin
    dup_hit    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    to_found   = 1'b0;
    to_idx     = '0;
    for (int i = 0; i < MAP_ENTRIES; i++) begin
      if (ent_valid[i] && ent_id[i] == reserve_id) dup_hit = 1'b1;
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (state == LOOKUP && ent_valid[i] && ent_id[i] == fill_id_q && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = IW'(i);
      end
    end
    for (int i = 0; i < MAP_ENTRIES; i++) begin
      if (ent_valid[i] && ent_age[i] == AGE_MAX && !to_found &&
          !(hit_found && hit_idx == IW'(i))) begin
        to_found = 1'b1;
        to_idx   = IW'(i);
      end
    end
  end

  // Map storage: aging, allocation, invalidation, occupancy and map pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAP_ENTRIES; i++) begin
        ent_valid[i] <= 1'b0;
        ent_id[i]    <= '0;
        ent_fifo[i]  <= '0;
        ent_addr[i]  <= '0;
        ent_age[i]   <= '0;
      end
      occupancy     <= '0;
      dup_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_fifo  <= '0;
      timeout_addr  <= '0;
    end else begin
      for (int i = 0; i < MAP_ENTRIES; i++) begin
        if (ent_valid[i] && ent_age[i] != AGE_MAX) ent_age[i] <= ent_age[i] + 8'd1;
      end
      if (hit_found) ent_valid[hit_idx] <= 1'b0;
      if (to_found)  ent_valid[to_idx]  <= 1'b0;
      if (do_alloc) begin
        ent_valid[free_idx] <= 1'b1;
        ent_id[free_idx]    <= reserve_id;
        ent_fifo[free_idx]  <= reserve_fifo;
        ent_addr[free_idx]  <= reserve_addr;
        ent_age[free_idx]   <= 8'd0;
      end
      occupancy     <= occupancy + OW'(do_alloc) - OW'(hit_found) - OW'(to_found);
      dup_pulse     <= dup_fire;
      timeout_pulse <= to_found;
      if (to_found) begin
        timeout_fifo <= ent_fifo[to_idx];
        timeout_addr <= ent_addr[to_idx];
      end
    end
  end

  // Resolver FSM with registered insert command and miss pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fill_id_q    <= '0;
      insert_valid <= 1'b0;
      insert_fifo  <= '0;
      insert_addr  <= '0;
      insert_id    <= '0;
      miss_pulse   <= 1'b0;
    end else begin
      miss_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_valid) begin
            fill_id_q <= fill_id;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_found) begin
            insert_valid <= 1'b1;
            insert_fifo  <= ent_fifo[hit_idx];
            insert_addr  <= ent_addr[hit_idx];
            insert_id    <= fill_id_q;
            state        <= ISSUE;
          end else begin
            miss_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        ISSUE: begin
          if (insert_ready) begin
            insert_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp5_phantom_ctrl.sv
// Directed bench for mp5_phantom_ctrl: instance a uses the default timeout,
// instance b uses TIMEOUT=4 for the aging scenario. Both share stimulus.
module tb_mp5_phantom_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reserve_valid;
  logic [15:0] reserve_id;
  logic [2:0]  reserve_fifo;
  logic [2:0]  reserve_addr;
  logic        fill_valid;
  logic [15:0] fill_id;
  logic        insert_ready;

  logic        a_reserve_ready, a_fill_ready, a_insert_valid, a_miss, a_dup, a_to;
  logic [2:0]  a_insert_fifo, a_insert_addr, a_to_fifo, a_to_addr;
  logic [15:0] a_insert_id;
  logic [4:0]  a_occ;

  logic        b_reserve_ready, b_fill_ready, b_insert_valid, b_miss, b_dup, b_to;
  logic [2:0]  b_insert_fifo, b_insert_addr, b_to_fifo, b_to_addr;
  logic [15:0] b_insert_id;
  logic [4:0]  b_occ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mp5_phantom_ctrl dut_a (
    .clk(clk), .rst(rst),
    .reserve_valid(reserve_valid), .reserve_id(reserve_id),
    .reserve_fifo(reserve_fifo), .reserve_addr(reserve_addr),
    .reserve_ready(a_reserve_ready),
    .fill_valid(fill_valid), .fill_id(fill_id), .fill_ready(a_fill_ready),
    .insert_valid(a_insert_valid), .insert_fifo(a_insert_fifo),
    .insert_addr(a_insert_addr), .insert_id(a_insert_id),
    .insert_ready(insert_ready),
    .miss_pulse(a_miss), .dup_pulse(a_dup),
    .timeout_pulse(a_to), .timeout_fifo(a_to_fifo), .timeout_addr(a_to_addr),
    .occupancy(a_occ)
  );

  mp5_phantom_ctrl #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .reserve_valid(reserve_valid), .reserve_id(reserve_id),
    .reserve_fifo(reserve_fifo), .reserve_addr(reserve_addr),
    .reserve_ready(b_reserve_ready),
    .fill_valid(fill_valid), .fill_id(fill_id), .fill_ready(b_fill_ready),
    .insert_valid(b_insert_valid), .insert_fifo(b_insert_fifo),
    .insert_addr(b_insert_addr), .insert_id(b_insert_id),
    .insert_ready(insert_ready),
    .miss_pulse(b_miss), .dup_pulse(b_dup),
    .timeout_pulse(b_to), .timeout_fifo(b_to_fifo), .timeout_addr(b_to_addr),
    .occupancy(b_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reserve(input logic [15:0] id, input logic [2:0] f, input logic [2:0] a);
    reserve_valid = 1'b1;
    reserve_id    = id;
    reserve_fifo  = f;
    reserve_addr  = a;
  endtask

  initial begin
    rst = 1'b1;
    reserve_valid = 1'b0; reserve_id = '0; reserve_fifo = '0; reserve_addr = '0;
    fill_valid = 1'b0; fill_id = '0; insert_ready = 1'b1;
    tick(); tick();
    chk("rst_insert_valid", a_insert_valid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_reserve_ready", a_reserve_ready, 1);
    chk("rst_fill_ready", a_fill_ready, 1);
    chk("rst_pulses", {a_miss, a_dup, a_to}, 0);
    chk("rst_insert_data", {a_insert_fifo, a_insert_addr, a_insert_id}, 0);
    rst = 1'b0;
    tick();

    // 1: reserve then resolve
    reserve(16'h0005, 3'd3, 3'd6);
    tick();
    reserve_valid = 1'b0;
    chk("t1_occ_after_reserve", a_occ, 1);
    fill_valid = 1'b1; fill_id = 16'h0005;
    tick();
    fill_valid = 1'b0;
    chk("t1_lookup_fill_ready", a_fill_ready, 0);
    chk("t1_lookup_insert_valid", a_insert_valid, 0);
    tick();
    chk("t1_insert_valid", a_insert_valid, 1);
    chk("t1_insert_fifo", a_insert_fifo, 3);
    chk("t1_insert_addr", a_insert_addr, 6);
    chk("t1_insert_id", a_insert_id, 16'h0005);
    chk("t1_occ_after_hit", a_occ, 0);
    tick();
    chk("t1_insert_drop", a_insert_valid, 0);
    chk("t1_fill_ready_back", a_fill_ready, 1);

    // 2: miss on empty map
    fill_valid = 1'b1; fill_id = 16'h00AA;
    tick();
    fill_valid = 1'b0;
    chk("t2_miss_early", a_miss, 0);
    tick();
    chk("t2_miss_pulse", a_miss, 1);
    chk("t2_fill_ready", a_fill_ready, 1);
    chk("t2_no_insert", a_insert_valid, 0);
    tick();
    chk("t2_miss_one_cycle", a_miss, 0);

    // 3: fill the map
    for (int i = 0; i < 16; i++) begin
      reserve(16'h0100 + 16'(i), 3'(i % 8), 3'((i + 1) % 8));
      tick();
      if (i == 7) chk("t3_occ_half", a_occ, 8);
    end
    reserve_valid = 1'b0;
    chk("t3_occ_full", a_occ, 16);
    chk("t3_reserve_ready_full", a_reserve_ready, 0);
    reserve(16'h0105, 3'd0, 3'd0);
    tick();
    reserve(16'h0200, 3'd1, 3'd1);
    chk("t3_full_no_dup", a_dup, 0);
    tick();
    reserve_valid = 1'b0;
    chk("t3_full_ignored_occ", a_occ, 16);
    fill_valid = 1'b1; fill_id = 16'h010A;
    tick();
    fill_valid = 1'b0;
    chk("t3_lookup_still_full", a_reserve_ready, 0);
    tick();
    chk("t3_ready_after_free", a_reserve_ready, 1);
    chk("t3_occ_15", a_occ, 15);
    chk("t3_insert_fifo", a_insert_fifo, 2);
    chk("t3_insert_addr", a_insert_addr, 3);
    reserve(16'h0300, 3'd7, 3'd7);
    tick();
    reserve_valid = 1'b0;
    chk("t3_refill_occ", a_occ, 16);
    chk("t3_refill_ready", a_reserve_ready, 0);
    chk("t3_insert_done", a_insert_valid, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_reset_occ", a_occ, 0);

    // 4: duplicate reserve
    reserve(16'h0010, 3'd5, 3'd4);
    tick();
    chk("t4_occ_first", a_occ, 1);
    chk("t4_no_dup_first", a_dup, 0);
    tick();
    reserve(16'h0020, 3'd1, 3'd2);
    chk("t4_dup_pulse", a_dup, 1);
    chk("t4_occ_after_dup", a_occ, 1);
    tick();
    reserve_valid = 1'b0;
    chk("t4_dup_one_cycle", a_dup, 0);
    chk("t4_occ_two", a_occ, 2);

    // 6: stalled insert, then reset mid-ISSUE
    insert_ready = 1'b0;
    fill_valid = 1'b1; fill_id = 16'h0010;
    tick();
    fill_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t6_stall_valid", a_insert_valid, 1);
      chk("t6_stall_data", {a_insert_fifo, a_insert_addr, a_insert_id}, {3'd5, 3'd4, 16'h0010});
      chk("t6_stall_fill_ready", a_fill_ready, 0);
      tick();
    end
    chk("t6_occ_before_rst", a_occ, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    insert_ready = 1'b1;
    chk("t6_rst_insert_valid", a_insert_valid, 0);
    chk("t6_rst_occ", a_occ, 0);
    chk("t6_rst_fill_ready", a_fill_ready, 1);

    // 5: aging on the TIMEOUT=4 instance
    reserve(16'h0001, 3'd2, 3'd1);
    tick();
    reserve(16'h0002, 3'd6, 3'd7);
    tick();
    reserve_valid = 1'b0;
    chk("t5_occ_two", b_occ, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_early_timeout", b_to, 0);
    end
    tick();
    chk("t5_first_pulse", b_to, 1);
    chk("t5_first_fifo", b_to_fifo, 2);
    chk("t5_first_addr", b_to_addr, 1);
    chk("t5_first_occ", b_occ, 1);
    tick();
    chk("t5_second_pulse", b_to, 1);
    chk("t5_second_fifo", b_to_fifo, 6);
    chk("t5_second_addr", b_to_addr, 7);
    chk("t5_second_occ", b_occ, 0);
    tick();
    chk("t5_pulse_end", b_to, 0);
    chk("t5_a_no_timeout", a_to, 0);
    chk("t5_a_occ", a_occ, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp5_phantom_ctrl.md
Name: mp5_phantom_ctrl

Overview:
- Per-stage controller that sequences the phantom-packet reservation / insert path of an mp5 stage.
- Records each phantom push (packet id -> FIFO id, slot address) in an associative map.
- When the real packet for a reserved id arrives, it resolves the id and drives the stage's insert command to overwrite the reserved slot.
- Ages reservations and reports stale ones (timeout) so the stage can retire the phantom. Sits beside each stage instance, between the stage push/insert ports and upstream steering.

Parameters:
- NUM_PIPELINES, 8, number of per-stage FIFOs; FIFO id width FW = clog2(NUM_PIPELINES).
- FIFO_SIZE, 8, slots per FIFO; slot address width AW = clog2(FIFO_SIZE).
- MAP_ENTRIES, 16, reservation map depth; power of 2, >= 2.
- ID_W, 16, packet id width.
- TIMEOUT, 255, cycles an entry may live before retirement; 1..255, age counter is 8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- reserve_valid  in  1  phantom pushed into stage FIFO
- reserve_id  in  ID_W  phantom packet id
- reserve_fifo  in  FW  FIFO holding the phantom
- reserve_addr  in  AW  slot address of the phantom
- reserve_ready  out  1  map has a free entry
- fill_valid  in  1  real packet requesting resolution
- fill_id  in  ID_W  id to resolve
- fill_ready  out  1  resolver idle
- insert_valid  out  1  insert command to stage
- insert_fifo  out  FW  target FIFO
- insert_addr  out  AW  target slot
- insert_id  out  ID_W  resolved id
- insert_ready  in  1  stage accepts insert
- miss_pulse  out  1  fill id not in map (1 cycle)
- dup_pulse  out  1  reserve id already mapped, dropped (1 cycle)
- timeout_pulse  out  1  entry retired by age (1 cycle)
- timeout_fifo  out  FW  retired entry FIFO
- timeout_addr  out  AW  retired entry slot
- occupancy  out  clog2(MAP_ENTRIES)+1  valid entry count

Behaviour:
- Entry: {valid, id, fifo, addr, age[7:0]}.
- Reset: all entries invalid. FSM = IDLE. All pulse and valid outputs 0. Data outputs 0. occupancy 0. reserve_ready 1, fill_ready 1.
- Reset mid-operation discards any pending insert; insert_valid is 0 in the cycle after rst.
- reserve_ready = (occupancy < MAP_ENTRIES). It uses the registered state only.
- Reserve handshake is reserve_valid & reserve_ready:
  - If id matches a valid entry: no allocation; dup_pulse next cycle.
  - Otherwise the lowest-index free entry is written with age 0 and becomes visible next cycle.
  - The free mask is the start-of-cycle mask; entries freed this cycle are reusable next cycle.
- Resolver FSM:
  - IDLE: fill_ready=1. On fill_valid, latch fill_id -> LOOKUP.
  - LOOKUP (1 cycle): compare the latched id against all valid entries.
    - Hit: latch fifo/addr/id into insert_* outputs, invalidate the entry, -> ISSUE.
    - Miss: miss_pulse next cycle, -> IDLE.
    - Multiple hits cannot occur because of the dup check.
  - ISSUE: insert_valid=1 with stable data until insert_ready, then -> IDLE (insert_valid 0 the following cycle).
- Fill-to-insert latency: insert_valid rises 2 cycles after the fill handshake. Sustained throughput is 1 fill per 3 cycles with insert_ready tied high.
- A reserve written in the same cycle as LOOKUP is not visible to that lookup.
- Aging:
  - Every valid entry's age increments each cycle, saturating at TIMEOUT.
  - Each cycle, the lowest-index entry with age==TIMEOUT is invalidated. timeout_pulse/fifo/addr are registered and appear next cycle. Others wait.
  - If LOOKUP hits an entry in the same cycle it would time out, the lookup wins and no timeout is reported.
- occupancy: registered; reflects allocate and free in the same cycle (net ±). Simultaneous alloc+free leaves it unchanged.
- Map full: reserve_ready=0; reserve_valid is ignored (no dup check, no pulse).

Test Plan:
1. After reset, reserve id 0x0005 fifo 3 addr 6, then fill 0x0005 with insert_ready=1 -> insert_valid 2 cycles after fill, fifo=3 addr=6 id=0x0005; occupancy 1->0.
2. Fill 0x00AA with empty map -> miss_pulse exactly 1 cycle, no insert_valid, fill_ready back to 1 on the next cycle.
3. Reserve 16 distinct ids -> reserve_ready=0, occupancy=16. A 17th reserve is ignored. Fill one id -> reserve_ready returns to 1 the cycle after the entry frees.
4. Reserve id 0x0010 twice -> dup_pulse once, occupancy stays 1.
5. TIMEOUT=4: reserve id 0x0001 fifo 2 addr 1, no fill -> timeout_pulse with fifo=2 addr=1 at 5-6 cycles after reserve; occupancy 0. Two entries expiring together report in consecutive cycles, lowest index first.
6. insert_ready held 0 for 5 cycles in ISSUE -> insert_* stable, fill_ready=0. Assert rst mid-ISSUE -> insert_valid=0, occupancy=0 next cycle.
